// File: rtl/ebox_data_path_if.sv
// Signal bundle between the EBOX data path and the rest of the EBOX.
// Latency: none of its own; it only carries wires.
// Backpressure: none; every signal is sampled or driven every cycle.
//
// Port summary:
//   inputs  : data sources (cache, EBUS, shifter, PC/VMA), CRAM/CTL decode fields
//             for the adders and the register loads and clears, and FM address and write enables
//   outputs : AD/ADX results and AD carry, register contents, FM word and parity,
//             cache write data, EBUS drive data and drive enable
// The slave modport faces the data path; the master modport faces the controller.
interface ebox_data_path_if;
  // data sources
  logic [35:0] cacheDataRead;
  logic [35:0] EBUS;
  logic [35:0] SHM_SH;
  logic [35:0] VMA_VMAheldOrPC;
  // adder control
  logic [5:0]  CRAM_AD;
  logic [2:0]  CRAM_ADA;
  logic        CRAM_ADA_EN;
  logic [1:0]  CRAM_ADB;
  logic        CTL_ADcarry36;
  logic        CTL_ADXcarry36;
  logic        CTL_ADlong;
  // register control
  logic [2:0]  CTL_ARL_SEL;
  logic [2:0]  CTL_ARR_SEL;
  logic        CTL_AR00to08load;
  logic        CTL_AR09to17load;
  logic        CTL_ARRload;
  logic        CTL_AR00to11clr;
  logic        CTL_AR12to17clr;
  logic        CTL_ARRclr;
  logic [2:0]  CTL_ARX_SEL;
  logic        CTL_ARX_LOAD;
  logic        CRAM_BRload;
  logic        CRAM_BRXload;
  logic [1:0]  CTL_MQ_SEL;
  // fast memory
  logic [2:0]  APR_FMblk;
  logic [3:0]  APR_FMadr;
  logic        CON_fmWrite00_17;
  logic        CON_fmWrite18_35;
  // EBUS drive control
  logic        CTL_adToEBUS_L;
  logic        CTL_adToEBUS_R;
  // outputs
  logic [37:0] EDP_AD;
  logic [35:0] EDP_ADX;
  logic        EDP_ADcarry;
  logic [35:0] EDP_AR;
  logic [35:0] EDP_ARX;
  logic [35:0] EDP_BR;
  logic [35:0] EDP_BRX;
  logic [35:0] EDP_MQ;
  logic [35:0] FM;
  logic        fmParity;
  logic [35:0] cacheDataWrite;
  logic [35:0] EDP_EBUS;
  logic        EDPdrivingEBUS;

  modport slave (
    input  cacheDataRead, EBUS, SHM_SH, VMA_VMAheldOrPC,
    input  CRAM_AD, CRAM_ADA, CRAM_ADA_EN, CRAM_ADB,
    input  CTL_ADcarry36, CTL_ADXcarry36, CTL_ADlong,
    input  CTL_ARL_SEL, CTL_ARR_SEL, CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload,
    input  CTL_AR00to11clr, CTL_AR12to17clr, CTL_ARRclr,
    input  CTL_ARX_SEL, CTL_ARX_LOAD, CRAM_BRload, CRAM_BRXload, CTL_MQ_SEL,
    input  APR_FMblk, APR_FMadr, CON_fmWrite00_17, CON_fmWrite18_35,
    input  CTL_adToEBUS_L, CTL_adToEBUS_R,
    output EDP_AD, EDP_ADX, EDP_ADcarry,
    output EDP_AR, EDP_ARX, EDP_BR, EDP_BRX, EDP_MQ,
    output FM, fmParity, cacheDataWrite, EDP_EBUS, EDPdrivingEBUS
  );

  modport master (
    output cacheDataRead, EBUS, SHM_SH, VMA_VMAheldOrPC,
    output CRAM_AD, CRAM_ADA, CRAM_ADA_EN, CRAM_ADB,
    output CTL_ADcarry36, CTL_ADXcarry36, CTL_ADlong,
    output CTL_ARL_SEL, CTL_ARR_SEL, CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload,
    output CTL_AR00to11clr, CTL_AR12to17clr, CTL_ARRclr,
    output CTL_ARX_SEL, CTL_ARX_LOAD, CRAM_BRload, CRAM_BRXload, CTL_MQ_SEL,
    output APR_FMblk, APR_FMadr, CON_fmWrite00_17, CON_fmWrite18_35,
    output CTL_adToEBUS_L, CTL_adToEBUS_R,
    input  EDP_AD, EDP_ADX, EDP_ADcarry,
    input  EDP_AR, EDP_ARX, EDP_BR, EDP_BRX, EDP_MQ,
    input  FM, fmParity, cacheDataWrite, EDP_EBUS, EDPdrivingEBUS
  );
endinterface

// File: rtl/ebox_data_path.sv
// KL10-style EBOX data path: AR/ARX/BR/BRX/MQ working registers, 128-word FM, AD/ADX adders.
// Latency: AD/ADX/FM/EBUS outputs are combinational; registers and FM update on the eboxClk edge.
// Backpressure: none; the controller drives every field every cycle.
//
// Ports: eboxClk, eboxResetN (async, active low) and the slave side of ebox_data_path_if.
// Bit numbering: the machine numbers bit 0 as the MSB. Vectors here are [35:0], so machine
// bit n lives at index 35-n; AD machine bits -2,-1 are EDP_AD[37:36].
module ebox_data_path #(
  parameter int FM_WORDS = 128
) (
  input logic              eboxClk,
  input logic              eboxResetN,
  ebox_data_path_if.slave  bus
);

  localparam logic [5:0] FN_A_CIN = 6'o00;
  localparam logic [5:0] FN_ADD   = 6'o06;
  localparam logic [5:0] FN_SUB   = 6'o11;
  localparam logic [5:0] FN_ZERO  = 6'o20;
  localparam logic [5:0] FN_AND   = 6'o21;
  localparam logic [5:0] FN_ONES  = 6'o23;
  localparam logic [5:0] FN_B     = 6'o25;
  localparam logic [5:0] FN_XOR   = 6'o26;
  localparam logic [5:0] FN_OR    = 6'o27;
  localparam logic [5:0] FN_NOTA  = 6'o32;
  localparam logic [5:0] FN_A     = 6'o37;

  // Left-half field masks in [35:0] numbering
  localparam logic [35:0] LH_MASK = 36'hFFFFC0000;
  localparam logic [35:0] RH_MASK = 36'h00003FFFF;

  // Bitwise functions; unknown codes pass A through.
  function automatic logic [35:0] logic_fn(input logic [35:0] a, input logic [35:0] b,
                                           input logic [5:0] fn);
    logic [35:0] r;
    case (fn)
      FN_ZERO: r = '0;
      FN_AND:  r = a & b;
      FN_XOR:  r = a ^ b;
      FN_OR:   r = a | b;
      FN_B:    r = b;
      FN_NOTA: r = ~a;
      FN_ONES: r = '1;
      FN_A:    r = a;
      default: r = a;
    endcase
    return r;
  endfunction

  logic [35:0] ar_q, arx_q, br_q, brx_q, mq_q;
  logic [35:0] ar_d, arx_d, br_d, brx_d, mq_d;

  logic [35:0] fm_mem [FM_WORDS];
  logic [6:0]  fm_addr;
  logic [35:0] fm_rd;

  logic [35:0] ada, adb;
  logic [37:0] a_ext, b_ext;
  logic        fn_arith;
  logic [35:0] ad_l, adx_l;
  logic [38:0] ad_sum;
  logic [36:0] adx_sum;
  logic [37:0] ad;
  logic [35:0] adx;
  logic        ad_cout, adx_cout, ad_cin;

  logic [35:0] src_bus [8];
  logic [17:0] arl_src, arr_src;

  // ---------------------------------------------------------------- FM read
  assign fm_addr = {bus.APR_FMblk, bus.APR_FMadr};
  assign fm_rd   = fm_mem[fm_addr];

  // ---------------------------------------------------------------- adder inputs
  always_comb begin
    ada = '0;
    if (!bus.CRAM_ADA_EN) begin
      case (bus.CRAM_ADA)
        3'd0:    ada = ar_q;
        3'd1:    ada = arx_q;
        3'd2:    ada = mq_q;
        3'd3:    ada = bus.VMA_VMAheldOrPC;
        default: ada = '0;
      endcase
    end
  end

  always_comb begin
    case (bus.CRAM_ADB)
      2'd0:    adb = fm_rd;
      2'd1:    adb = {br_q[34:0], 1'b0};
      2'd2:    adb = br_q;
      default: adb = {ar_q[33:0], 2'b00};
    endcase
  end

  assign a_ext    = {{2{ada[35]}}, ada};
  assign b_ext    = {{2{adb[35]}}, adb};
  assign fn_arith = (bus.CRAM_AD == FN_ADD) || (bus.CRAM_AD == FN_SUB) ||
                    (bus.CRAM_AD == FN_A_CIN);

  // ---------------------------------------------------------------- ADX (ARX op BRX)
  assign adx_l = logic_fn(arx_q, brx_q, bus.CRAM_AD);

  always_comb begin
    case (bus.CRAM_AD)
      FN_ADD:   adx_sum = {1'b0, arx_q} + {1'b0, brx_q} + 37'(bus.CTL_ADXcarry36);
      FN_SUB:   adx_sum = {1'b0, arx_q} + {1'b0, ~brx_q} + 37'(bus.CTL_ADXcarry36);
      FN_A_CIN: adx_sum = {1'b0, arx_q} + 37'(bus.CTL_ADXcarry36);
      default:  adx_sum = '0;
    endcase
  end

  assign adx      = fn_arith ? adx_sum[35:0] : adx_l;
  assign adx_cout = fn_arith & adx_sum[36];

  // ---------------------------------------------------------------- AD (38-bit)
  // In long mode the ADX carry-out replaces the AD carry-in, making a 72-bit add.
  assign ad_cin = bus.CTL_ADlong ? adx_cout : bus.CTL_ADcarry36;

  // Bits -2,-1 of a bitwise result equal bit 0 because both operands are
  // sign-extended, so the 36-bit logic result only needs its MSB replicated.
  assign ad_l = logic_fn(ada, adb, bus.CRAM_AD);

  always_comb begin
    case (bus.CRAM_AD)
      FN_ADD:   ad_sum = {1'b0, a_ext} + {1'b0, b_ext} + 39'(ad_cin);
      FN_SUB:   ad_sum = {1'b0, a_ext} + {1'b0, ~b_ext} + 39'(ad_cin);
      FN_A_CIN: ad_sum = {1'b0, a_ext} + 39'(ad_cin);
      default:  ad_sum = '0;
    endcase
  end

  assign ad      = fn_arith ? ad_sum[37:0] : {{2{ad_l[35]}}, ad_l};
  assign ad_cout = fn_arith & ad_sum[38];

  // ---------------------------------------------------------------- register sources
  // Index 0 means hold and is resolved per destination below.
  // AD>>2 takes its fill from AD bits -2,-1, giving an arithmetic shift of the 38-bit result.
  always_comb begin
    src_bus[0] = '0;
    src_bus[1] = bus.cacheDataRead;
    src_bus[2] = ad[35:0];
    src_bus[3] = bus.EBUS;
    src_bus[4] = bus.SHM_SH;
    src_bus[5] = {ad[34:0], 1'b0};
    src_bus[6] = adx;
    src_bus[7] = ad[37:2];
  end

  assign arl_src = (bus.CTL_ARL_SEL == 3'd0) ? ar_q[35:18] : src_bus[bus.CTL_ARL_SEL][35:18];
  assign arr_src = (bus.CTL_ARR_SEL == 3'd0) ? ar_q[17:0]  : src_bus[bus.CTL_ARR_SEL][17:0];

  // ---------------------------------------------------------------- next state
  always_comb begin
    ar_d = ar_q;
    // loads first, then clears so that a clear overrides a load on the same field
    if (bus.CTL_AR00to08load) ar_d[35:27] = arl_src[17:9];
    if (bus.CTL_AR09to17load) ar_d[26:18] = arl_src[8:0];
    if (bus.CTL_ARRload)      ar_d[17:0]  = arr_src;
    if (bus.CTL_AR00to11clr)  ar_d[35:24] = '0;
    if (bus.CTL_AR12to17clr)  ar_d[23:18] = '0;
    if (bus.CTL_ARRclr)       ar_d[17:0]  = '0;
  end

  always_comb begin
    arx_d = arx_q;
    if (bus.CTL_ARX_LOAD && (bus.CTL_ARX_SEL != 3'd0)) arx_d = src_bus[bus.CTL_ARX_SEL];
  end

  assign br_d  = bus.CRAM_BRload  ? ar_q  : br_q;
  assign brx_d = bus.CRAM_BRXload ? arx_q : brx_q;

  always_comb begin
    case (bus.CTL_MQ_SEL)
      2'd0:    mq_d = mq_q;
      2'd1:    mq_d = bus.SHM_SH;
      2'd2:    mq_d = {mq_q[34:0], 1'b0};
      default: mq_d = ad[35:0];
    endcase
  end

  always_ff @(posedge eboxClk or negedge eboxResetN) begin
    if (!eboxResetN) begin
      ar_q  <= '0;
      arx_q <= '0;
      br_q  <= '0;
      brx_q <= '0;
      mq_q  <= '0;
    end else begin
      ar_q  <= ar_d;
      arx_q <= arx_d;
      br_q  <= br_d;
      brx_q <= brx_d;
      mq_q  <= mq_d;
    end
  end

  // FM is plain storage with no reset; halves are written from the pre-edge AR.
  always_ff @(posedge eboxClk) begin
    if (bus.CON_fmWrite00_17) fm_mem[fm_addr][35:18] <= ar_q[35:18];
    if (bus.CON_fmWrite18_35) fm_mem[fm_addr][17:0]  <= ar_q[17:0];
  end

  // ---------------------------------------------------------------- outputs
  assign bus.EDP_AD         = ad;
  assign bus.EDP_ADX        = adx;
  assign bus.EDP_ADcarry    = ad_cout;
  assign bus.EDP_AR         = ar_q;
  assign bus.EDP_ARX        = arx_q;
  assign bus.EDP_BR         = br_q;
  assign bus.EDP_BRX        = brx_q;
  assign bus.EDP_MQ         = mq_q;
  assign bus.FM             = fm_rd;
  assign bus.fmParity       = ~^fm_rd;
  assign bus.cacheDataWrite = ar_q;
  assign bus.EDP_EBUS       = (bus.CTL_adToEBUS_L ? (ad[35:0] & LH_MASK) : 36'd0) |
                              (bus.CTL_adToEBUS_R ? (ad[35:0] & RH_MASK) : 36'd0);
  assign bus.EDPdrivingEBUS = bus.CTL_adToEBUS_L | bus.CTL_adToEBUS_R;

endmodule

// File: tb/tb_ebox_data_path.sv
module tb_ebox_data_path;

  localparam longint unsigned M36 = 64'hF_FFFF_FFFF;
  localparam longint unsigned M38 = 64'h3F_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ebox_data_path_if bus();

  ebox_data_path #(.FM_WORDS(128)) dut (
    .eboxClk    (clk),
    .eboxResetN (rst_n),
    .bus        (bus)
  );

  typedef struct {
    logic [35:0] cache, ebus, sh, pc;
    logic [5:0]  fn;
    logic [2:0]  ada;
    logic        ada_en;
    logic [1:0]  adb;
    logic        cin, xcin, adlong;
    logic [2:0]  arl, arr, arxs;
    logic        ld0, ld9, ldr, c0, c12, cr, arxld, brld, brxld;
    logic [1:0]  mq;
    logic [2:0]  blk;
    logic [3:0]  fma;
    logic        wl, wr, el, er;
  } stim_t;

  typedef struct {
    longint unsigned ad, adcy, adx, ar, arx, br, brx, mq, fm, par, ebus, drv;
    bit fm_ok;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  // reference state
  longint unsigned m_ar, m_arx, m_br, m_brx, m_mq;
  longint unsigned m_fm [128];
  bit              m_fml [128];
  bit              m_fmr [128];

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] r36();
    return {4'($urandom()), 32'($urandom())};
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.fn = 6'o37;
    return s;
  endfunction

  // 36-bit two's complement value sign-extended into a 38-bit pattern
  function automatic longint unsigned sx38(input longint unsigned v);
    return (v >= 64'h8_0000_0000) ? (v + 64'h30_0000_0000) : v;
  endfunction

  // Adder function on w-bit operands; result bit w is the carry out.
  function automatic longint unsigned m_alu(input longint unsigned a, input longint unsigned b,
                                            input longint unsigned cin, input logic [5:0] fn,
                                            input int w);
    longint unsigned m;
    m = (64'd1 << w) - 1;
    case (fn)
      6'o06:   return a + b + cin;
      6'o11:   return a + ((~b) & m) + cin;
      6'o00:   return a + cin;
      6'o20:   return 0;
      6'o21:   return a & b;
      6'o26:   return a ^ b;
      6'o27:   return a | b;
      6'o25:   return b;
      6'o32:   return (~a) & m;
      6'o23:   return m;
      default: return a;
    endcase
  endfunction

  function automatic longint unsigned m_src(input logic [2:0] sel, input longint unsigned hold,
                                            input stim_t s, input longint unsigned ad,
                                            input longint unsigned adx);
    case (sel)
      3'd1:    return 64'(s.cache);
      3'd2:    return ad & M36;
      3'd3:    return 64'(s.ebus);
      3'd4:    return 64'(s.sh);
      3'd5:    return (ad * 2) & M36;
      3'd6:    return adx;
      3'd7:    return (ad >> 2) & M36;
      default: return hold;
    endcase
  endfunction

  task automatic drive(input stim_t s);
    bus.cacheDataRead    = s.cache;
    bus.EBUS             = s.ebus;
    bus.SHM_SH           = s.sh;
    bus.VMA_VMAheldOrPC  = s.pc;
    bus.CRAM_AD          = s.fn;
    bus.CRAM_ADA         = s.ada;
    bus.CRAM_ADA_EN      = s.ada_en;
    bus.CRAM_ADB         = s.adb;
    bus.CTL_ADcarry36    = s.cin;
    bus.CTL_ADXcarry36   = s.xcin;
    bus.CTL_ADlong       = s.adlong;
    bus.CTL_ARL_SEL      = s.arl;
    bus.CTL_ARR_SEL      = s.arr;
    bus.CTL_AR00to08load = s.ld0;
    bus.CTL_AR09to17load = s.ld9;
    bus.CTL_ARRload      = s.ldr;
    bus.CTL_AR00to11clr  = s.c0;
    bus.CTL_AR12to17clr  = s.c12;
    bus.CTL_ARRclr       = s.cr;
    bus.CTL_ARX_SEL      = s.arxs;
    bus.CTL_ARX_LOAD     = s.arxld;
    bus.CRAM_BRload      = s.brld;
    bus.CRAM_BRXload     = s.brxld;
    bus.CTL_MQ_SEL       = s.mq;
    bus.APR_FMblk        = s.blk;
    bus.APR_FMadr        = s.fma;
    bus.CON_fmWrite00_17 = s.wl;
    bus.CON_fmWrite18_35 = s.wr;
    bus.CTL_adToEBUS_L   = s.el;
    bus.CTL_adToEBUS_R   = s.er;
  endtask

  // One machine cycle: drive at the falling edge, queue the expected view of this
  // cycle, then advance the reference state to what the next rising edge produces.
  task automatic step(input stim_t s);
    exp_t e;
    int addr;
    longint unsigned a, b, adx_full, ad_full, ad, adx, cin, nar, l, r;
    @(negedge clk);
    drive(s);
    addr = int'(s.blk) * 16 + int'(s.fma);
    if (s.ada_en) a = 0;
    else case (s.ada)
      3'd0: a = m_ar;
      3'd1: a = m_arx;
      3'd2: a = m_mq;
      3'd3: a = 64'(s.pc);
      default: a = 0;
    endcase
    case (s.adb)
      2'd0: b = m_fm[addr];
      2'd1: b = (m_br * 2) & M36;
      2'd2: b = m_br;
      default: b = (m_ar * 4) & M36;
    endcase
    adx_full = m_alu(m_arx, m_brx, 64'(s.xcin), s.fn, 36);
    adx = adx_full & M36;
    cin = s.adlong ? ((adx_full >> 36) & 1) : 64'(s.cin);
    ad_full = m_alu(sx38(a), sx38(b), cin, s.fn, 38);
    ad = ad_full & M38;
    e.ad = ad;
    e.adcy = (ad_full >> 38) & 1;
    e.adx = adx;
    e.ar = m_ar; e.arx = m_arx; e.br = m_br; e.brx = m_brx; e.mq = m_mq;
    e.fm = m_fm[addr];
    e.par = ($countones(m_fm[addr]) % 2 == 0) ? 1 : 0;
    e.fm_ok = m_fml[addr] && m_fmr[addr];
    e.ebus = (s.el ? (ad & 64'hF_FFFC_0000) : 0) | (s.er ? (ad & 64'h3_FFFF) : 0);
    e.drv = (s.el || s.er) ? 1 : 0;
    exp_q.push_back(e);

    // next state: loads by field, then clears override
    l = m_src(s.arl, m_ar, s, ad, adx);
    r = m_src(s.arr, m_ar, s, ad, adx);
    nar = m_ar;
    if (s.ld0) nar = (nar & ~64'hF_F800_0000) | (l & 64'hF_F800_0000);
    if (s.ld9) nar = (nar & ~64'h0_07FC_0000) | (l & 64'h0_07FC_0000);
    if (s.ldr) nar = (nar & ~64'h0_0003_FFFF) | (r & 64'h0_0003_FFFF);
    if (s.c0)  nar = nar & ~64'hF_FF00_0000;
    if (s.c12) nar = nar & ~64'h0_00FC_0000;
    if (s.cr)  nar = nar & ~64'h0_0003_FFFF;
    if (s.wl) begin
      m_fm[addr] = (m_fm[addr] & 64'h3_FFFF) | (m_ar & 64'hF_FFFC_0000);
      m_fml[addr] = 1'b1;
    end
    if (s.wr) begin
      m_fm[addr] = (m_fm[addr] & 64'hF_FFFC_0000) | (m_ar & 64'h3_FFFF);
      m_fmr[addr] = 1'b1;
    end
    if (s.brld)  m_br = m_ar;
    if (s.brxld) m_brx = m_arx;
    if (s.arxld) m_arx = m_src(s.arxs, m_arx, s, ad, adx);
    case (s.mq)
      2'd1: m_mq = 64'(s.sh);
      2'd2: m_mq = (m_mq * 2) & M36;
      2'd3: m_mq = ad & M36;
      default: ;
    endcase
    m_ar = nar;
  endtask

  // Monitor: pops one expectation per cycle, sampling late in the low phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("AD", 64'(bus.EDP_AD), e.ad);
        check("ADcarry", 64'(bus.EDP_ADcarry), e.adcy);
        check("ADX", 64'(bus.EDP_ADX), e.adx);
        check("AR", 64'(bus.EDP_AR), e.ar);
        check("ARX", 64'(bus.EDP_ARX), e.arx);
        check("BR", 64'(bus.EDP_BR), e.br);
        check("BRX", 64'(bus.EDP_BRX), e.brx);
        check("MQ", 64'(bus.EDP_MQ), e.mq);
        check("cacheDataWrite", 64'(bus.cacheDataWrite), e.ar);
        check("EDP_EBUS", 64'(bus.EDP_EBUS), e.ebus);
        check("EDPdrivingEBUS", 64'(bus.EDPdrivingEBUS), e.drv);
        if (e.fm_ok) begin
          check("FM", 64'(bus.FM), e.fm);
          check("fmParity", 64'(bus.fmParity), e.par);
        end
      end
    end
  end

  initial begin
    stim_t s;
    logic [5:0] codes [12];
    int guard;
    codes = '{6'o06, 6'o11, 6'o00, 6'o20, 6'o21, 6'o26, 6'o27, 6'o25, 6'o32, 6'o23, 6'o37, 6'o05};
    m_ar = 0; m_arx = 0; m_br = 0; m_brx = 0; m_mq = 0;
    for (int i = 0; i < 128; i++) begin m_fm[i] = 0; m_fml[i] = 0; m_fmr[i] = 0; end
    drive(idle());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state, AD = A = AR = 0
    step(idle());
    #3;
    check("reset_AR", 64'(bus.EDP_AR), 0);
    check("reset_AD", 64'(bus.EDP_AD), 0);

    // give every FM word a known value (AR is zero)
    for (int i = 0; i < 128; i++) begin
      s = idle(); s.blk = 3'(i / 16); s.fma = 4'(i % 16); s.wl = 1; s.wr = 1;
      step(s);
    end

    // cycle 1 / cycle 2 of the basic load and add sequence
    s = idle(); s.cache = 36'h123456789; s.arl = 1; s.arr = 1;
    s.ld0 = 1; s.ld9 = 1; s.ldr = 1; s.brld = 1;
    step(s);
    s.fn = 6'o06; s.adb = 2; s.cache = 36'h987654321;
    step(s);
    #3;
    check("c2_AD_pre", 64'(bus.EDP_AD), 64'h123456789);
    check("c2_BR_pre", 64'(bus.EDP_BR), 0);
    s = idle(); s.fn = 6'o06; s.adb = 2;
    step(s);
    #3;
    check("c2_AR", 64'(bus.EDP_AR), 64'h987654321);
    check("c2_BR", 64'(bus.EDP_BR), 64'h123456789);
    check("c2_AD38", 64'(bus.EDP_AD), 64'h3AAAAAAAAA);

    // clear beats load on AR bits 0-11
    s = idle(); s.cache = 36'h123456789; s.arl = 1; s.arr = 1; s.ld0 = 1; s.ld9 = 1; s.ldr = 1;
    step(s);
    s.cache = 36'hFFFFFFFFF; s.c0 = 1;
    step(s);
    step(idle());
    #3;
    check("clr_AR", 64'(bus.EDP_AR), 64'h000FFFFFF);

    // FM write of both halves, then left half only
    s = idle(); s.cache = 36'h0000000FF; s.arl = 1; s.arr = 1; s.ld0 = 1; s.ld9 = 1; s.ldr = 1;
    step(s);
    s = idle(); s.fma = 7; s.wl = 1; s.wr = 1;
    step(s);
    s = idle(); s.fma = 7;
    step(s);
    #3;
    check("fm_word", 64'(bus.FM), 64'h0FF);
    check("fm_parity", 64'(bus.fmParity), 1);
    s = idle(); s.cache = 36'hFFFFFFFFF; s.arl = 1; s.arr = 1; s.ld0 = 1; s.ld9 = 1; s.ldr = 1;
    step(s);
    s = idle(); s.fma = 7; s.wl = 1;
    step(s);
    s = idle(); s.fma = 7;
    step(s);
    #3;
    check("fm_half", 64'(bus.FM), 64'hFFFFC00FF);

    // AD left half onto EBUS
    s = idle(); s.cache = 36'h123456789; s.arl = 1; s.arr = 1; s.ld0 = 1; s.ld9 = 1; s.ldr = 1;
    step(s);
    s = idle(); s.el = 1;
    step(s);
    #3;
    check("ebus_L", 64'(bus.EDP_EBUS), 64'h123440000);
    check("ebus_drv", 64'(bus.EDPdrivingEBUS), 1);

    // randomized traffic against the reference model
    for (int n = 0; n < 1500; n++) begin
      s = idle();
      s.cache = r36(); s.ebus = r36(); s.sh = r36(); s.pc = r36();
      s.fn = ($urandom_range(0, 7) == 0) ? 6'($urandom()) : codes[$urandom_range(0, 11)];
      s.ada = 3'($urandom()); s.ada_en = ($urandom_range(0, 7) == 0);
      s.adb = 2'($urandom());
      s.cin = 1'($urandom()); s.xcin = 1'($urandom()); s.adlong = 1'($urandom());
      s.arl = 3'($urandom()); s.arr = 3'($urandom()); s.arxs = 3'($urandom());
      s.ld0 = 1'($urandom()); s.ld9 = 1'($urandom()); s.ldr = 1'($urandom());
      s.c0 = ($urandom_range(0, 7) == 0); s.c12 = ($urandom_range(0, 7) == 0);
      s.cr = ($urandom_range(0, 7) == 0);
      s.arxld = 1'($urandom()); s.brld = 1'($urandom()); s.brxld = 1'($urandom());
      s.mq = 2'($urandom());
      s.blk = 3'($urandom()); s.fma = 4'($urandom());
      s.wl = ($urandom_range(0, 3) == 0); s.wr = ($urandom_range(0, 3) == 0);
      s.el = 1'($urandom()); s.er = 1'($urandom());
      step(s);
    end

    step(idle());
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #4;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ebox_data_path.md
Name: ebox_data_path

Overview:
- 36-bit EBOX data path of the KL10-style processor.
- Holds working registers AR, ARX, BR, BRX and MQ, plus a 128-word fast-memory (FM) AC file.
- Combines them through a 38-bit main adder (AD) and a 36-bit extension adder (ADX) under decoded CRAM/CTL control fields.
- Sources and sinks data to the cache, shifter (SH), EBUS and PC.

Parameters:
- FM_WORDS, 128, fast-memory depth (8 blocks × 16 ACs).

Ports:
- eboxClk  in  1  EBOX clock; all state updates on its rising edge.
- eboxResetN  in  1  asynchronous active-low reset.
- cacheDataRead  in  36  data from cache.
- EBUS  in  36  external bus data.
- SHM_SH  in  36  shifter output.
- VMA_VMAheldOrPC  in  36  PC/VMA value.
- CRAM_AD  in  6  AD function code.
- CRAM_ADA  in  3  A-input select.
- CRAM_ADA_EN  in  1  1 = force A input to 0.
- CRAM_ADB  in  2  B-input select.
- CTL_ADcarry36  in  1  AD carry-in.
- CTL_ADXcarry36  in  1  ADX carry-in.
- CTL_ADlong  in  1  chain ADX carry-out into AD.
- CTL_ARL_SEL, CTL_ARR_SEL  in  3 each  AR left / right source select.
- CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload  in  1 each  AR field load enables.
- CTL_AR00to11clr, CTL_AR12to17clr, CTL_ARRclr  in  1 each  AR field clears.
- CTL_ARX_SEL  in  3  ARX source select.
- CTL_ARX_LOAD  in  1  ARX load enable.
- CRAM_BRload, CRAM_BRXload  in  1 each  BR/BRX load enables.
- CTL_MQ_SEL  in  2  MQ operation.
- APR_FMblk  in  3  FM block number.
- APR_FMadr  in  4  FM AC number.
- CON_fmWrite00_17, CON_fmWrite18_35  in  1 each  FM half-word write enables.
- CTL_adToEBUS_L, CTL_adToEBUS_R  in  1 each  drive AD halves onto EBUS.
- EDP_AD  out  38  AD result, bits -2..35.
- EDP_ADX  out  36  ADX result.
- EDP_ADcarry  out  1  AD carry-out from bit -2.
- EDP_AR, EDP_ARX, EDP_BR, EDP_BRX, EDP_MQ  out  36 each  register contents.
- FM  out  36  FM word at current address.
- fmParity  out  1  odd-parity bit of FM.
- cacheDataWrite  out  36  equals AR.
- EDP_EBUS  out  36  EBUS drive data.
- EDPdrivingEBUS  out  1  EBUS drive active.

Behaviour:
- Reset (async, eboxResetN=0): AR, ARX, BR, BRX and MQ cleared to 0. FM contents are not reset.
- Bit 0 is the MSB throughout.
- A input:
  - CRAM_ADA_EN=1 forces A=0.
  - Otherwise ADA: 0 AR, 1 ARX, 2 MQ, 3 PC; codes 4-7 give 0.
- B input (ADB): 0 FM, 1 BR<<1, 2 BR, 3 AR<<2. Shifts fill with 0 and are truncated to 36 bits.
- AD sign extension: A and B are sign-extended from bit 0 to 38 bits (bits -2, -1) before the operation.
- AD functions, octal codes:
  - 06 A+B+cin.
  - 11 A+~B+cin (A-B when cin=1).
  - 00 A+cin.
  - 20 zero.
  - 21 A&B.
  - 26 A^B.
  - 27 A|B.
  - 25 B.
  - 32 ~A.
  - 23 all ones.
  - 37 A.
  - Any other code: A.
- AD carry-in (cin): CTL_ADcarry36, or the ADX carry-out when CTL_ADlong=1. Logic functions ignore cin.
- EDP_ADcarry is the carry out of bit -2 for arithmetic codes and 0 for logic codes.
- ADX: same function code applied to A=ARX, B=BRX, carry-in CTL_ADXcarry36, 36 bits wide. AD and ADX are purely combinational.
- AR/ARX source codes (same for ARL, ARR and ARX): 0 hold, 1 cacheDataRead, 2 AD[0:35], 3 EBUS, 4 SHM_SH, 5 AD<<1, 6 ADX, 7 AD>>2 (arithmetic shift).
  - ARL_SEL feeds AR bits 0-17; ARR_SEL feeds AR bits 18-35.
- AR update at each edge, per field:
  - Clear wins over load, which wins over hold.
  - Fields: bits 0-8 load; 9-17 load; 18-35 load and clear; bits 0-11 and 12-17 clear.
- ARX loads the selected source when CTL_ARX_LOAD=1.
- BR<=AR when CRAM_BRload=1; BRX<=ARX when CRAM_BRXload=1.
  - Both take the pre-edge AR/ARX value (non-blocking semantics).
- MQ (CTL_MQ_SEL): 0 hold, 1 SHM_SH, 2 MQ<<1 (bit35<-0), 3 AD[0:35].
- FM:
  - Address = {APR_FMblk, APR_FMadr}; read is combinational.
  - On the edge, AR[0:17] is written if CON_fmWrite00_17 and AR[18:35] if CON_fmWrite18_35.
  - Read-during-write returns the old data until the edge.
- EBUS drive:
  - EDP_EBUS[0:17] = AD[0:17] if adToEBUS_L, else 0.
  - EDP_EBUS[18:35] = AD[18:35] if adToEBUS_R, else 0.
  - EDPdrivingEBUS = L|R.

Test Plan:
- Reset -> all registers 0; AD=0 with code 37.
- Cycle 1: cache=123456789, ARL/ARR sel=1, all AR loads=1, BRload=1, AD=37 -> after edge AR=123456789, BR=0, AD=123456789.
- Cycle 2: AD=06, ADB=2, cache=987654321, same loads -> before edge AD=123456789. After edge AR=987654321, BR=123456789, AD[0:35]=AAAAAAAAA, AD[-2:-1]=11.
- AR=123456789, CTL_AR00to11clr=1 together with all loads (cache=FFFFFFFFF) -> AR=000FFFFFF.
- AR=0000000FF written to FM blk0/AC7 with both write enables -> FM=0000000FF, fmParity=1. Write with only 00_17 enabled -> right half unchanged.
- AD=A=123456789, adToEBUS_L=1, R=0 -> EDP_EBUS=123440000 (AD[0:17]=048D1 in left half), EDPdrivingEBUS=1.
